// File: rtl/emulador_de_teclado.sv
// emulador_de_teclado: emulates one press of a 4x4 matrix keypad key as seen by a row scanner.
//   Parameters: HOLD_CYCLES (closed time), RELEASE_CYCLES (guaranteed open time),
//               BOUNCE_CYCLES (bounce time, used only when EMULADOR_BOUNCE_EN is defined).
//   Ports: clk, rst (async, active-high); lin_matriz[3:0] active-low rows (bit 3 = row 0);
//          key_value[3:0] hex key; press_start one-clock request;
//          col_matriz[3:0] active-low columns; busy sequence in progress; done end pulse.
//   Build option: define EMULADOR_BOUNCE_EN to add a pseudo-random bounce phase before HOLD.
module emulador_de_teclado #(
   parameter int HOLD_CYCLES    = 200,
   parameter int RELEASE_CYCLES = 200,
   parameter int BOUNCE_CYCLES  = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] lin_matriz,
   input  logic [3:0] key_value,
   input  logic       press_start,
   output logic [3:0] col_matriz,
   output logic       busy,
   output logic       done
);
   // Counters are loaded with length-1 and run down to 0; a zero length still gives one clock.
   localparam logic [15:0] H_LD = 16'((HOLD_CYCLES < 1 ? 1 : HOLD_CYCLES) - 1);
   localparam logic [15:0] R_LD = 16'((RELEASE_CYCLES < 1 ? 1 : RELEASE_CYCLES) - 1);
`ifdef EMULADOR_BOUNCE_EN
   localparam logic [15:0] B_LD = 16'((BOUNCE_CYCLES < 1 ? 1 : BOUNCE_CYCLES) - 1);
   typedef enum logic [1:0] {IDLE, BOUNCE, HOLD, RELEASE} state_t;
   logic [7:0] lfsr_q, lfsr_d;
`else
   typedef enum logic [1:0] {IDLE, HOLD, RELEASE} state_t;
`endif
   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [3:0]  key_q, key_d;
   logic        done_q, done_d;
   logic [3:0]  pos;
   logic        closed;
   // Key code to {row index, column index} of the keypad layout 1 2 3 A / 4 5 6 B / 7 8 9 C / D 0 E F.
   function automatic logic [3:0] key_pos(input logic [3:0] k);
      case (k)
         4'h1: key_pos = 4'b0000;
         4'h2: key_pos = 4'b0001;
         4'h3: key_pos = 4'b0010;
         4'hA: key_pos = 4'b0011;
         4'h4: key_pos = 4'b0100;
         4'h5: key_pos = 4'b0101;
         4'h6: key_pos = 4'b0110;
         4'hB: key_pos = 4'b0111;
         4'h7: key_pos = 4'b1000;
         4'h8: key_pos = 4'b1001;
         4'h9: key_pos = 4'b1010;
         4'hC: key_pos = 4'b1011;
         4'hD: key_pos = 4'b1100;
         4'h0: key_pos = 4'b1101;
         4'hE: key_pos = 4'b1110;
         default: key_pos = 4'b1111;
      endcase
   endfunction
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      key_d   = key_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: if (press_start) begin
            key_d = key_value;
`ifdef EMULADOR_BOUNCE_EN
            state_d = BOUNCE;
            cnt_d   = B_LD;
`else
            state_d = HOLD;
            cnt_d   = H_LD;
`endif
         end
`ifdef EMULADOR_BOUNCE_EN
         BOUNCE: begin
            state_d = cnt_q == 16'd0 ? HOLD : BOUNCE;
            cnt_d   = cnt_q == 16'd0 ? H_LD : cnt_q - 16'd1;
         end
`endif
         HOLD: begin
            state_d = cnt_q == 16'd0 ? RELEASE : HOLD;
            cnt_d   = cnt_q == 16'd0 ? R_LD : cnt_q - 16'd1;
         end
         RELEASE: begin
            state_d = cnt_q == 16'd0 ? IDLE : RELEASE;
            cnt_d   = cnt_q == 16'd0 ? 16'd0 : cnt_q - 16'd1;
            done_d  = cnt_q == 16'd0;
         end
         default: state_d = IDLE;
      endcase
   end
`ifdef EMULADOR_BOUNCE_EN
   // Fibonacci LFSR for x^8+x^6+x^5+x^4+1, free-running.
   always_comb lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   always_ff @(posedge clk or posedge rst)
      if (rst) lfsr_q <= 8'hA5;
      else     lfsr_q <= lfsr_d;
   assign closed = state_q == HOLD || (state_q == BOUNCE && lfsr_q[0]);
`else
   assign closed = state_q == HOLD;
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 16'd0;
         key_q   <= 4'h0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         key_q   <= key_d;
         done_q  <= done_d;
      end
   // Switch path: row index r drives lin_matriz[3-r], i.e. the bitwise inverse of the 2-bit index.
   assign pos        = key_pos(key_q);
   assign col_matriz = closed && !lin_matriz[~pos[3:2]] ? ~(4'b1000 >> pos[1:0]) : 4'b1111;
   assign busy       = state_q != IDLE;
   assign done       = done_q;
endmodule

// File: tb/tb_emulador_de_teclado.sv
// tb_emulador_de_teclado: self-checking bench for emulador_de_teclado (default, no-bounce build).
module tb_emulador_de_teclado;
   localparam int H = 200;
   localparam int R = 200;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] lin_matriz = 4'hF;
   logic [3:0] key_value = 4'h0;
   logic       press_start = 1'b0;
   logic [3:0] col_matriz;
   logic       busy;
   logic       done;
   int n_cmp = 0;
   int n_bad = 0;
   int n_done = 0;
   // Keypad table: row pattern and column pattern per key code.
   logic [3:0] rp [16] = '{4'b1110, 4'b0111, 4'b0111, 4'b0111, 4'b1011, 4'b1011, 4'b1011, 4'b1101,
                           4'b1101, 4'b1101, 4'b0111, 4'b1011, 4'b1101, 4'b1110, 4'b1110, 4'b1110};
   logic [3:0] cp [16] = '{4'b1011, 4'b0111, 4'b1011, 4'b1101, 4'b0111, 4'b1011, 4'b1101, 4'b0111,
                           4'b1011, 4'b1101, 4'b1110, 4'b1110, 4'b1110, 4'b0111, 4'b1101, 4'b1110};
   // Model: age = clocks since the accepting edge, -1 when idle; closed while age < H.
   int         age = -1;
   logic [3:0] m_key = 4'h0;
   logic       m_done = 1'b0;
   emulador_de_teclado #(.HOLD_CYCLES(H), .RELEASE_CYCLES(R), .BOUNCE_CYCLES(16)) dut (
      .clk(clk), .rst(rst), .lin_matriz(lin_matriz), .key_value(key_value),
      .press_start(press_start), .col_matriz(col_matriz), .busy(busy), .done(done));
   always #5 clk = ~clk;
   always @(posedge clk or posedge rst)
      if (rst) begin
         age = -1;
         m_key = 4'h0;
         m_done = 1'b0;
      end else begin
         m_done = 1'b0;
         if (age >= 0) begin
            age++;
            if (age == H + R) begin
               age = -1;
               m_done = 1'b1;
            end
         end else if (press_start) begin
            age = 0;
            m_key = key_value;
         end
      end
   function automatic logic [3:0] exp_col();
      return (age >= 0 && age < H && (lin_matriz | rp[m_key]) != 4'hF) ? cp[m_key] : 4'hF;
   endfunction
   task automatic check(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask
   always @(negedge clk) begin
      check("col", int'(col_matriz), int'(exp_col()));
      check("busy", int'(busy), int'(age >= 0));
      check("done", int'(done), int'(m_done));
      if (done) n_done++;
   end
   task automatic press(input logic [3:0] k);
      @(posedge clk); #2;
      press_start = 1'b1;
      key_value = k;
      @(posedge clk); #2;
      press_start = 1'b0;
   endtask
   task automatic wait_idle();
      int n = 0;
      while (busy && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", int'(busy), 0);
      @(negedge clk);
   endtask
   task automatic profile(input logic [3:0] pat, output int nb, output int nc, output int nd);
      nb = 0; nc = 0; nd = 0;
      repeat (420) begin
         @(negedge clk);
         if (busy) nb++;
         if (col_matriz == pat) nc++;
         if (done) nd++;
      end
   endtask
   logic [3:0] rows [6] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110, 4'b1111, 4'b0000};
   initial begin
      int nb, nc, nd, d0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      check("reset_col", int'(col_matriz), 'hF);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      // Key 5 on its row: 200 closed, 200 open, single done; latch cycle plus busy = 401.
      lin_matriz = 4'b1011;
      press(4'h5);
      profile(4'b1011, nb, nc, nd);
      check("k5_busy_width", nb + 1, 401);
      check("k5_closed", nc, 200);
      check("k5_done", nd, 1);
      // Key A with rotating rows: closed only on row 0.
      press(4'hA);
      for (int i = 0; i < H; i++) begin
         lin_matriz = rows[i % 4];
         @(negedge clk);
         check("kA_rot", int'(col_matriz), lin_matriz == 4'b0111 ? 'hE : 'hF);
         @(posedge clk); #2;
      end
      wait_idle();
      // Sweep every key against every row pattern, plus all-high and all-low rows.
      for (int k = 0; k < 16; k++) begin
         press(4'(k));
         for (int j = 0; j < 6; j++) begin
            lin_matriz = rows[j];
            @(posedge clk); #2;
         end
         wait_idle();
      end
      // Press during HOLD is ignored: key 1 stays latched, one done.
      lin_matriz = 4'b0111;
      d0 = n_done;
      press(4'h1);
      repeat (20) @(posedge clk);
      #2 press(4'h9);
      @(negedge clk);
      check("ignore_col", int'(col_matriz), 'h7);
      wait_idle();
      check("ignore_done", n_done - d0, 1);
      // Reset at HOLD clock 50 aborts immediately, no done; next press runs full length.
      lin_matriz = 4'b1011;
      d0 = n_done;
      press(4'h5);
      repeat (50) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("rst_col", int'(col_matriz), 'hF);
      check("rst_busy", int'(busy), 0);
      @(posedge clk); #2 rst = 1'b0;
      repeat (5) @(negedge clk);
      check("rst_no_done", n_done - d0, 0);
      press(4'h5);
      profile(4'b1011, nb, nc, nd);
      check("rst_busy_width", nb + 1, 401);
      check("rst_closed", nc, 200);
      // Back-to-back: press in the done cycle is accepted.
      lin_matriz = 4'b0111;
      press(4'h3);
      nb = 0;
      while (!done && nb < 1000) begin
         @(negedge clk);
         nb++;
      end
      check("b2b_done_seen", int'(done), 1);
      press_start = 1'b1;
      key_value = 4'hD;
      @(posedge clk); #2 press_start = 1'b0;
      lin_matriz = 4'b1110;
      @(negedge clk);
      check("b2b_busy", int'(busy), 1);
      check("b2b_col", int'(col_matriz), 'h7);
      wait_idle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/emulador_de_teclado.md
EMULADOR_DE_TECLADO -- requirements
Module: emulador_de_teclado

Interface
REQ-001 Parameter HOLD_CYCLES, default 200: clocks the emulated key stays closed in HOLD.
REQ-002 Parameter RELEASE_CYCLES, default 200: clocks of guaranteed open contact after HOLD.
REQ-003 Parameter BOUNCE_CYCLES, default 16: clocks of contact bounce before HOLD (bounce build only).
REQ-004 clk  input  1  clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 lin_matriz  input  4  row drive from the scanner, active-low; bit 3 = row 0 (keys 1,2,3,A).
REQ-007 key_value  input  4  hex code of the key to emulate.
REQ-008 press_start  input  1  one-clock request to start a press of key_value.
REQ-009 col_matriz  output  4  column lines, active-low, 4'b1111 when no contact.
REQ-010 busy  output  1  high while a press sequence is in progress.
REQ-011 done  output  1  one-clock pulse at end of a press sequence.

Function
REQ-012 States SHALL be IDLE, BOUNCE, HOLD, RELEASE; state and counter encoded in registers, counter 16 bits.
REQ-013 In IDLE, press_start=1 at edge N SHALL latch key_value, load counter, and enter BOUNCE (bounce build) or HOLD (otherwise) at edge N.
REQ-014 press_start SHALL be ignored in any state other than IDLE; latched key SHALL not change mid-sequence.
REQ-015 Key map (row pattern/col pattern): 1 0111/0111, 2 0111/1011, 3 0111/1101, A 0111/1110, 4 1011/0111, 5 1011/1011, 6 1011/1101, B 1011/1110, 7 1101/0111, 8 1101/1011, 9 1101/1101, C 1101/1110, D 1110/0111, 0 1110/1011, E 1110/1101, F 1110/1110.
REQ-016 Contact closed SHALL mean: col_matriz = latched col pattern whenever the latched row's bit of lin_matriz is 0, else 4'b1111; this path SHALL be combinational from lin_matriz (zero-cycle, like a physical switch).
REQ-017 lin_matriz values with several rows low SHALL still close contact if the latched row bit is 0; 4'b1111 SHALL give col_matriz = 4'b1111.
REQ-018 HOLD SHALL keep contact closed exactly HOLD_CYCLES clocks, then enter RELEASE.
REQ-019 RELEASE SHALL keep contact open (col_matriz = 4'b1111) exactly RELEASE_CYCLES clocks, then enter IDLE.
REQ-020 done SHALL be 1 for exactly the clock cycle following the RELEASE->IDLE edge; busy SHALL be 1 in BOUNCE, HOLD, RELEASE, 0 in IDLE.
REQ-021 In IDLE, col_matriz SHALL be 4'b1111 regardless of lin_matriz.
REQ-022 A new press_start in the same cycle done is high SHALL be accepted (back-to-back sequences).
REQ-023 Parameters of value 0 SHALL be treated as 1 (minimum one clock per state).

Reset
REQ-024 rst SHALL force state IDLE, counter 0, latched key 4'h0, col_matriz 4'b1111, busy 0, done 0, LFSR 8'hA5, asynchronously and in any state.
REQ-025 Reset mid-sequence SHALL abort it with no done pulse; first press_start after rst release SHALL be honored.

Configuration
REQ-026 Macro EMULADOR_BOUNCE_EN SHALL compile in the BOUNCE state and an 8-bit LFSR (x^8+x^6+x^5+x^4+1, advancing every clock).
REQ-027 With EMULADOR_BOUNCE_EN: BOUNCE lasts BOUNCE_CYCLES clocks, contact closed only when LFSR bit 0 = 1, then HOLD.
REQ-028 Without EMULADOR_BOUNCE_EN: no LFSR, no BOUNCE state, IDLE goes directly to HOLD; BOUNCE_CYCLES unused.

Verification
REQ-029 No-bounce, HOLD=200, RELEASE=200: press key 5, lin_matriz=1011 -> col_matriz=1011 for 200 clocks, then 1111 for 200, done pulse once, busy 401 clocks wide incl. latch.
REQ-030 Key A held, lin_matriz rotating 0111/1011/1101/1110 each clock -> col_matriz=1110 only when lin_matriz=0111, else 1111.
REQ-031 Sweep all 16 key codes with lin_matriz forced to each row pattern -> col_matriz matches REQ-015 table exactly, 1111 on other rows.
REQ-032 press_start pulsed during HOLD with key 9 -> ignored, sequence completes for original key 1, single done.
REQ-033 rst asserted at HOLD clock 50 -> col_matriz=1111, busy=0 immediately, no done; new press after release runs full length.
REQ-034 EMULADOR_BOUNCE_EN, BOUNCE=16, key 0, lin_matriz=1110 -> col_matriz toggles 1011/1111 per LFSR for 16 clocks, then steady 1011 for HOLD_CYCLES.
